// File: rtl/loss_batch_mean_if.sv
// Handshake bundle between the loss stage, the batch-mean block and the training controller.
interface loss_batch_mean_if #(
  parameter int IL    = 8,
  parameter int FL    = 12,
  parameter int ACC_W = 26,
  parameter int BW    = 9
);
  logic                      start;
  logic [BW-1:0]             batch_num;
  logic                      busy;
  logic signed [IL+FL-1:0]   loss_in;
  logic                      loss_valid;
  logic                      loss_ready;
  logic signed [IL+FL-1:0]   mean_out;
  logic signed [ACC_W-1:0]   total_out;
  logic                      overflow;
  logic                      mean_valid;
  logic                      mean_ready;

  modport master (
    output start, batch_num, loss_in, loss_valid, mean_ready,
    input  busy, loss_ready, mean_out, total_out, overflow, mean_valid
  );

  modport slave (
    input  start, batch_num, loss_in, loss_valid, mean_ready,
    output busy, loss_ready, mean_out, total_out, overflow, mean_valid
  );
endinterface

// File: rtl/loss_batch_mean.sv
// Accumulates a runtime-sized batch of signed loss samples with saturation and
// reports the batch total and the truncated-toward-zero mean.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; results hold their last values
// S_ACCUM  | loss_ready high, summing samples until N are accepted
// S_DIVIDE | restoring divide of |acc| by N, one quotient bit per cycle
// S_OUTPUT | mean_valid high, results held until mean_ready
module loss_batch_mean #(
  parameter int IL     = 8,
  parameter int FL     = 12,
  parameter int ACC_IL = 14,
  parameter int MAXB   = 256,
  parameter int ACC_W  = ACC_IL + FL,
  parameter int BW     = $clog2(MAXB + 1)
) (
  input logic clk,
  input logic reset,
  loss_batch_mean_if.slave bus
);

  localparam int LW = IL + FL;
  localparam int CW = $clog2(ACC_W);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DIVIDE, S_OUTPUT} state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    n_q, n_d;
  logic [BW-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [BW-1:0]    rem_q, rem_d;
  logic [ACC_W-1:0] quo_q, quo_d;
  logic [CW-1:0]    step_q, step_d;
  logic             neg_q, neg_d;
  logic [LW-1:0]    mean_q, mean_d;
  logic [ACC_W-1:0] total_q, total_d;
  logic             ovf_out_q, ovf_out_d;

  logic             accept;
  logic [ACC_W:0]   sum_wide;
  logic             sum_clip;
  logic [ACC_W-1:0] sum_sat;
  logic [ACC_W-1:0] abs_sum;
  logic [BW:0]      trial;
  logic             trial_ge;
  logic [BW:0]      trial_sub;
  logic [ACC_W-1:0] quo_next;
  logic [ACC_W-1:0] quo_signed;

  assign accept = (state_q == S_ACCUM) && bus.loss_valid;

  // One extra guard bit; a sign mismatch between the top two bits means the sum left the range.
  always_comb begin
    sum_wide = {acc_q[ACC_W-1], acc_q}
             + {{(ACC_W+1-LW){bus.loss_in[LW-1]}}, bus.loss_in};
    sum_clip = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    if (!sum_clip)           sum_sat = sum_wide[ACC_W-1:0];
    else if (sum_wide[ACC_W]) sum_sat = ACC_MIN;
    else                     sum_sat = ACC_MAX;
    abs_sum = sum_sat[ACC_W-1] ? (~sum_sat + ACC_W'(1)) : sum_sat;
  end

  // The remainder stays below N, so a BW-bit remainder plus one shifted-in bit never overflows.
  always_comb begin
    trial      = {rem_q, quo_q[ACC_W-1]};
    trial_ge   = (trial >= {1'b0, n_q});
    trial_sub  = trial - {1'b0, n_q};
    quo_next   = {quo_q[ACC_W-2:0], trial_ge};
    quo_signed = neg_q ? (~quo_next + ACC_W'(1)) : quo_next;
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    step_d    = step_q;
    neg_d     = neg_q;
    mean_d    = mean_q;
    total_d   = total_q;
    ovf_out_d = ovf_out_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          n_d   = (bus.batch_num > BW'(MAXB)) ? BW'(MAXB) : bus.batch_num;
          cnt_d = '0;
          acc_d = '0;
          ovf_d = 1'b0;
          if (bus.batch_num == '0) begin
            state_d   = S_OUTPUT;
            mean_d    = '0;
            total_d   = '0;
            ovf_out_d = 1'b0;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (accept) begin
          acc_d = sum_sat;
          cnt_d = cnt_q + BW'(1);
          ovf_d = ovf_q | sum_clip;
          if (cnt_d == n_q) begin
            state_d = S_DIVIDE;
            rem_d   = '0;
            quo_d   = abs_sum;
            neg_d   = sum_sat[ACC_W-1];
            step_d  = CW'(ACC_W - 1);
          end
        end
      end
      S_DIVIDE: begin
        rem_d  = trial_ge ? trial_sub[BW-1:0] : trial[BW-1:0];
        quo_d  = quo_next;
        step_d = step_q - CW'(1);
        if (step_q == '0) begin
          state_d   = S_OUTPUT;
          mean_d    = quo_signed[LW-1:0];
          total_d   = acc_q;
          ovf_out_d = ovf_q;
        end
      end
      S_OUTPUT: begin
        if (bus.mean_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      step_q    <= '0;
      neg_q     <= 1'b0;
      mean_q    <= '0;
      total_q   <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      step_q    <= step_d;
      neg_q     <= neg_d;
      mean_q    <= mean_d;
      total_q   <= total_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign bus.loss_ready = (state_q == S_ACCUM);
  assign bus.mean_valid = (state_q == S_OUTPUT);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.mean_out   = mean_q;
  assign bus.total_out  = total_q;
  assign bus.overflow   = ovf_out_q;

endmodule

// File: tb/tb_loss_batch_mean.sv
// Directed bench for loss_batch_mean: stimulus pushes expected results, a monitor pops and compares.
module tb_loss_batch_mean;

  logic clk;
  logic reset;

  loss_batch_mean_if bif ();

  loss_batch_mean dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  typedef struct {
    longint mean;
    longint total;
    longint ovf;
  } exp_t;

  exp_t sb[$];
  int   samp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset && bif.mean_valid && bif.mean_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mean_out", longint'(bif.mean_out), e.mean);
        chk("total_out", longint'(bif.total_out), e.total);
        chk("overflow", longint'(bif.overflow), e.ovf);
      end
    end
  end

  task automatic send(input int v, input bit rnd);
    int guard;
    guard = 0;
    if (rnd) begin
      while ($urandom_range(0, 1) == 1 && guard < 8) begin
        bif.loss_valid = 1'b0;
        bif.loss_in    = 20'sh7FFFF;
        @(posedge clk); #1;
        guard++;
      end
    end
    bif.loss_in    = 20'(v);
    bif.loss_valid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!bif.loss_ready && guard < 50);
    chk("loss_ready_seen", longint'(bif.loss_ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic run_batch(input int n, input longint e_mean, input longint e_total,
                           input longint e_ovf, input bit stall, input bit rnd, input bit poke);
    exp_t e;
    int   cycles;
    bit   seen_ready;
    e.mean  = e_mean;
    e.total = e_total;
    e.ovf   = e_ovf;
    sb.push_back(e);
    bif.batch_num  = 9'(n);
    bif.mean_ready = !stall;
    @(posedge clk); #1;
    bif.start = 1'b1;
    @(posedge clk); #1;
    bif.start = 1'b0;
    seen_ready = bif.loss_ready;
    for (int i = 0; i < samp_q.size(); i++) begin
      send(samp_q[i], rnd);
      if (poke && i == 0) begin
        bif.loss_valid = 1'b0;
        bif.start      = 1'b1;
        bif.batch_num  = 9'd1;
        @(posedge clk); #1;
        bif.start = 1'b0;
      end
    end
    bif.loss_valid = 1'b0;
    cycles = 0;
    while (!bif.mean_valid && cycles < 400) begin
      if (bif.loss_ready) seen_ready = 1'b1;
      bif.start = poke && (cycles == 5);
      @(posedge clk); #1;
      cycles++;
    end
    bif.start = 1'b0;
    if (n == 0) chk("n0_no_loss_ready", longint'(seen_ready), 0);
    else        chk("latency", cycles, 26);
    if (stall) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        chk("stall_valid", longint'(bif.mean_valid), 1);
        chk("stall_mean", longint'(bif.mean_out), e_mean);
        chk("stall_total", longint'(bif.total_out), e_total);
      end
      @(posedge clk); #1;
      bif.mean_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("valid_drop", longint'(bif.mean_valid), 0);
    chk("busy_drop", longint'(bif.busy), 0);
    bif.mean_ready = 1'b1;
  endtask

  initial begin
    reset          = 1'b0;
    bif.start      = 1'b0;
    bif.batch_num  = '0;
    bif.loss_in    = '0;
    bif.loss_valid = 1'b0;
    bif.mean_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", longint'(bif.busy), 0);
    chk("rst_mean_valid", longint'(bif.mean_valid), 0);
    chk("rst_loss_ready", longint'(bif.loss_ready), 0);
    chk("rst_mean", longint'(bif.mean_out), 0);
    chk("rst_total", longint'(bif.total_out), 0);
    chk("rst_ovf", longint'(bif.overflow), 0);
    reset = 1'b1;

    samp_q = '{4096, 8192, 12288, 16384};
    run_batch(4, 10240, 40960, 0, 0, 0, 0);

    samp_q = '{-12288, 4096};
    run_batch(2, -4096, -8192, 0, 0, 0, 0);

    samp_q = '{-1, -1, 0};
    run_batch(3, 0, -2, 0, 0, 0, 0);

    samp_q.delete();
    for (int i = 0; i < 100; i++) samp_q.push_back(524287);
    run_batch(100, 335544, 33554431, 1, 0, 0, 0);

    samp_q = '{5};
    run_batch(1, 5, 5, 0, 0, 0, 0);

    samp_q = '{100, 200, 301};
    run_batch(3, 200, 601, 0, 1, 1, 0);

    samp_q.delete();
    run_batch(0, 0, 0, 0, 0, 0, 0);

    samp_q = '{1000, 3000};
    run_batch(2, 2000, 4000, 0, 0, 0, 1);

    samp_q.delete();
    for (int i = 0; i < 256; i++) samp_q.push_back(3);
    run_batch(300, 3, 768, 0, 0, 0, 0);

    // Abort an N=4 batch partway through the divide; no result may appear.
    bif.batch_num = 9'd4;
    @(posedge clk); #1;
    bif.start = 1'b1;
    @(posedge clk); #1;
    bif.start = 1'b0;
    for (int i = 0; i < 4; i++) send(4096, 0);
    bif.loss_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("mid_divide_busy", longint'(bif.busy), 1);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk("async_rst_busy", longint'(bif.busy), 0);
    chk("async_rst_valid", longint'(bif.mean_valid), 0);
    chk("async_rst_mean", longint'(bif.mean_out), 0);
    chk("async_rst_total", longint'(bif.total_out), 0);
    chk("async_rst_ovf", longint'(bif.overflow), 0);
    @(negedge clk);
    reset = 1'b1;

    samp_q = '{-4096, -4096, -4096, -4095};
    run_batch(4, -4095, -16383, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
